// File: rtl/recip_share_arbiter.sv
// Round-robin time-sharing of one integer reciprocal unit (y = floor(65536/x)) among NREQ requesters.
// Latency: req_ready to rsp_valid is CALC_CYC+1 cycles, or 1 cycle when x == 0 (saturated result).
// Backpressure: one operation in flight; rsp_valid/rsp_y held until rsp_ready[grant], new grants wait.
// Optional: define RECIP_SHARE_DIV0_FLAG_EN for rsp_div0 and per-requester div-by-zero counters.
module recip_share_arbiter #(
  parameter int NREQ     = 4,
  parameter int CALC_CYC = 1,
  parameter int XW       = 10,
  parameter int YW       = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*XW-1:0] req_x,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [YW-1:0]     rsp_y,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              busy,
  output logic              recip_enb,
  output logic [XW-1:0]     recip_x,
  input  logic [YW-1:0]     recip_y
`ifdef RECIP_SHARE_DIV0_FLAG_EN
  ,
  output logic              rsp_div0,
  output logic [NREQ*8-1:0] div0_cnt
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (CALC_CYC > 1) ? $clog2(CALC_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CALC  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   grant_idx;
  logic [CW-1:0]   calc_cnt;

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [XW-1:0]   pick_x;
  logic [IW-1:0]   ptr_nxt;
  logic [IW:0]     cand_sum;

  // First valid requester at or after the pointer; scanning from the far end lets the nearest win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_sum = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand_sum = {1'b0, ptr} + (IW+1)'(i);
      if (cand_sum >= (IW+1)'(NREQ)) begin
        cand_sum = cand_sum - (IW+1)'(NREQ);
      end
      if (req_valid[cand_sum[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand_sum[IW-1:0];
      end
    end
  end

  assign pick_x  = req_x[pick_idx*XW +: XW];
  assign ptr_nxt = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

  // Accept strobe only exists in the GRANT cycle, so a requester that withdrew is simply passed over.
  assign req_ready = (state == GRANT && pick_vld) ? (NREQ'(1) << pick_idx) : '0;
  assign busy      = (state != IDLE);

  // Main sequencer: grant, hold the unit enabled for CALC_CYC cycles, then present the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      calc_cnt  <= '0;
      recip_enb <= 1'b0;
      recip_x   <= '0;
      rsp_valid <= '0;
      rsp_y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) state <= GRANT;
        end
        GRANT: begin
          if (pick_vld) begin
            grant_idx <= pick_idx;
            recip_x   <= pick_x;
            ptr       <= ptr_nxt;
            calc_cnt  <= '0;
            if (pick_x != '0) begin
              recip_enb <= 1'b1;
              state     <= CALC;
            end else begin
              // Divide by zero never touches the unit; answer saturates.
              rsp_y     <= '1;
              rsp_valid <= NREQ'(1) << pick_idx;
              state     <= RESP;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (calc_cnt == CW'(CALC_CYC - 1)) begin
            recip_enb <= 1'b0;
            rsp_y     <= recip_y;
            rsp_valid <= NREQ'(1) << grant_idx;
            state     <= RESP;
          end else begin
            calc_cnt <= calc_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[grant_idx]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RECIP_SHARE_DIV0_FLAG_EN
  logic [7:0] div0_q [NREQ];

  // Flag rides along with rsp_valid; per-requester counters stick at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_div0 <= 1'b0;
      for (int i = 0; i < NREQ; i++) div0_q[i] <= '0;
    end else begin
      if (state == GRANT && pick_vld && pick_x == '0) begin
        rsp_div0 <= 1'b1;
        if (div0_q[pick_idx] != 8'hFF) div0_q[pick_idx] <= div0_q[pick_idx] + 8'd1;
      end else if (state == GRANT && pick_vld) begin
        rsp_div0 <= 1'b0;
      end else if (state == RESP && rsp_ready[grant_idx]) begin
        rsp_div0 <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_div0
    assign div0_cnt[g*8 +: 8] = div0_q[g];
  end
`endif

endmodule
